mem_cfg_arbiter: RTL and testbench
==================================

Name: mem_cfg_arbiter

Overview:
Shares the switch memory/configuration bus (mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s, mem_rd_data, mem_ack) between N_REQ requesters, such as the port-config sequencer, the stats reader and the TB driver. It arbitrates round-robin and runs one bus transaction at a time. Each transaction is held stable until mem_ack or a timeout, then the read data or an error is returned to the winning requester. It sits between the requesters and the DUT side of the memory interface and drives it as the drv_mp modport does.

Parameters:
N_REQ, 4, number of requesters (>=2)
TIMEOUT, 16, max cycles in BUSY waiting for mem_ack before error (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req  in  N_REQ  per-requester request, held high until its done pulse
req_addr  in  N_REQ*8  per-requester register address, slice i = [8i+7:8i]
req_wdata  in  N_REQ*8  per-requester write data
req_wr_rd_s  in  N_REQ  per-requester 1=write, 0=read
done  out  N_REQ  one-cycle completion pulse to the granted requester
rsp_rdata  out  8  read data, valid in the done cycle
rsp_err  out  1  timeout flag, valid in the done cycle
busy  out  1  high in BUSY and DONE
mem_sel_en  out  1  bus enable
mem_addr  out  8  bus address
mem_wr_data  out  8  bus write data
mem_wr_rd_s  out  1  bus direction
mem_rd_data  in  8  bus read data
mem_ack  in  1  bus acknowledge

Behaviour:
- Reset (rst_n=0 sampled at an edge): state=IDLE, every output 0, rr pointer=0, timeout counter=0. This applies mid-transaction too: mem_sel_en drops the cycle after reset is sampled, and no done pulse is issued.
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE, when req!=0:
  - Pick the winner: the first asserted req scanning upward from ptr and wrapping N_REQ-1 -> 0.
  - Latch the winner's addr, wdata and wr_rd_s onto mem_addr/mem_wr_data/mem_wr_rd_s.
  - Set mem_sel_en=1, clear cnt, go to BUSY.
  - Latency: req high at edge k gives mem_sel_en=1 after edge k.
- BUSY:
  - mem_sel_en and all bus fields stay constant.
  - cnt increments each cycle.
  - If mem_ack=1 is sampled, the transaction succeeds. For a read, capture mem_rd_data into rsp_rdata; for a write, rsp_rdata=0. rsp_err=0. Go to DONE.
  - Otherwise, when cnt==TIMEOUT-1 at the edge, the transaction fails: rsp_err=1, rsp_rdata=0, go to DONE.
  - mem_ack and the timeout expiring on the same edge: ack wins.
  - An ack sampled on the first BUSY edge is accepted (1-cycle transaction).
- DONE:
  - mem_sel_en=0. done[winner]=1 for exactly one cycle. rsp_* hold their values.
  - ptr = winner+1 mod N_REQ. Go to IDLE.
  - rsp_* are cleared on leaving DONE.
- mem_sel_en is always low for at least 2 cycles (DONE plus IDLE) between transactions.
- mem_ack while in IDLE or DONE is ignored.
- A requester dropping req while in BUSY has no effect: the transaction completes and done still pulses.
- A requester that keeps req high past its done pulse is re-arbitrated as a new request at lower priority.
- At most one done bit is ever high. done is one-hot or zero.
- mem_addr/mem_wr_data/mem_wr_rd_s keep their last values in IDLE. Only mem_sel_en qualifies them.

Decomposition:
- Package mem_cfg_pkg holds:
  - constants MEM_ADDR_W=8, MEM_DATA_W=8, WR=1'b1, RD=1'b0
  - typedef enum logic[1:0] {IDLE, BUSY, DONE} arb_state_t
- Sub-module rr_arbiter: purely combinational, with inputs req[N_REQ] and ptr and outputs a one-hot grant and an index. It is reusable by other shared resources.

Test Plan:
- Single write: req[1]=1, addr=8'h10, wdata=8'hA5, wr=1; ack 3 cycles after sel_en -> mem_sel_en high 3 cycles with addr=10/data=A5/wr=1, done[1] pulses once, rsp_err=0.
- Read: req[2]=1, addr=8'h04, rd; ack on first BUSY cycle with mem_rd_data=8'h3C -> rsp_rdata=8'h3C with done[2], 1-cycle sel_en.
- Round-robin: all req=4'hF held after reset -> grant order 0,1,2,3,0. Each sel_en burst is separated by >=2 low cycles.
- Timeout: TIMEOUT=16, ack never asserted -> sel_en high exactly 16 cycles, done pulses with rsp_err=1, rsp_rdata=0.
- Ack on timeout edge: ack at cycle 16 -> rsp_err=0 and data captured.
- Reset mid-BUSY: rst_n=0 for 1 cycle during a transaction -> all outputs 0 next cycle, no done. The following transaction with req=4'b1010 is granted to index 1 (ptr reset to 0).

Source files
------------

// File: rtl/mem_cfg_pkg.sv
`default_nettype none
// ============================================================================
// mem_cfg_pkg - bus widths, direction codes and arbiter state type
// Revision 1.0
// ============================================================================
package mem_cfg_pkg;
    localparam int   MEM_ADDR_W = 8;
    localparam int   MEM_DATA_W = 8;
    localparam logic WR         = 1'b1;
    localparam logic RD         = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter - combinational round-robin pick, first request at or above ptr
// Revision 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o
);
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    // Scan from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(N_REQ);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (req_i[w_pos]) begin
                grant_o        = '0;
                grant_o[w_pos] = 1'b1;
                idx_o          = w_pos;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// mem_cfg_arbiter - round-robin sharing of the memory/config bus, one
// transaction at a time with ack-or-timeout completion.  Revision 1.0
// ============================================================================
module mem_cfg_arbiter
    import mem_cfg_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*MEM_ADDR_W-1:0] req_addr,
    input  logic [N_REQ*MEM_DATA_W-1:0] req_wdata,
    input  logic [N_REQ-1:0]            req_wr_rd_s,
    output logic [N_REQ-1:0]            done,
    output logic [MEM_DATA_W-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        mem_sel_en,
    output logic [MEM_ADDR_W-1:0]       mem_addr,
    output logic [MEM_DATA_W-1:0]       mem_wr_data,
    output logic                        mem_wr_rd_s,
    input  logic [MEM_DATA_W-1:0]       mem_rd_data,
    input  logic                        mem_ack
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       win_idx_q, win_idx_d;
    logic [N_REQ-1:0]       win_oh_q, win_oh_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sel_q, sel_d;
    logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
    logic [MEM_DATA_W-1:0]  wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic [MEM_DATA_W-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic [N_REQ-1:0]       w_grant;
    logic [IDX_W-1:0]       w_idx;
    logic [MEM_ADDR_W-1:0]  w_addr  [N_REQ];
    logic [MEM_DATA_W-1:0]  w_wdata [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_addr[i]  = req_addr[i*MEM_ADDR_W +: MEM_ADDR_W];
        assign w_wdata[i] = req_wdata[i*MEM_DATA_W +: MEM_DATA_W];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        busy_d    = busy_q;
        unique case (state_q)
            IDLE: begin
                if (req != '0) begin
                    win_idx_d = w_idx;
                    win_oh_d  = w_grant;
                    addr_d    = w_addr[w_idx];
                    wdata_d   = w_wdata[w_idx];
                    wr_d      = req_wr_rd_s[w_idx];
                    sel_d     = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // An ack on the expiry edge still counts as success.
                if (mem_ack) begin
                    rdata_d = (wr_q == WR) ? '0 : mem_rd_data;
                    err_d   = 1'b0;
                    sel_d   = 1'b0;
                    done_d  = win_oh_q;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = 1'b0;
                    done_d  = win_oh_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
                ptr_d   = (win_idx_q == IDX_W'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= RD;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_sel_en  = sel_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign mem_wr_rd_s = wr_q;
    assign done        = done_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign busy        = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_cfg_arbiter - transaction-timeline model of the arbiter, directed
// scenarios with literal expectations, then randomized traffic.  Revision 1.0
// ============================================================================
module tb_mem_cfg_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [7:0]     ra  [N];
    logic [7:0]     rwd [N];
    logic [N*8-1:0] req_addr;
    logic [N*8-1:0] req_wdata;
    logic [N-1:0]   req_wr_rd_s = '0;
    logic [N-1:0]   done;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic           busy;
    logic           mem_sel_en;
    logic [7:0]     mem_addr;
    logic [7:0]     mem_wr_data;
    logic           mem_wr_rd_s;
    logic [7:0]     mem_rd_data = '0;
    logic           mem_ack = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*8 +: 8]  = ra[i];
            req_wdata[i*8 +: 8] = rwd[i];
        end
    end

    mem_cfg_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wr_rd_s (req_wr_rd_s),
        .done        (done),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mem_sel_en  (mem_sel_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_rd_s (mem_wr_rd_s),
        .mem_rd_data (mem_rd_data),
        .mem_ack     (mem_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one transaction is a grant edge tg, an ack delay td and a bus
    // length tL; every output is a closed-form function of (edge - tg).
    int         e = 0;
    bit         tv = 0;
    int         tg = 0, td = 0, tL = 0, tw = 0;
    logic [7:0] t_rdata = '0;
    bit         t_err = 0, t_wr = 0;
    int         ptr = 0;
    logic       exp_sel = 0, exp_wr = 0, exp_err = 0, exp_busy = 0;
    logic [7:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
    logic [N-1:0] exp_done = '0;
    bit         chk_en = 0;

    int  force_d  = -1;
    int  rd_fix   = -1;
    bit  rand_mode = 0;
    bit  spur_en  = 0;
    bit  hold_req = 0;

    int  sel_cnt = 0, low_run = 0, min_gap = 999;
    bit  prev_sel = 0, seen_burst = 0;
    int  done_q[$];
    logic [7:0] last_rdata = '0;
    logic       last_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step();
        int rel;
        int r;
        if (!rst_n) begin
            tv = 0; ptr = 0;
            exp_sel = 0; exp_addr = '0; exp_wdata = '0; exp_wr = 0;
            exp_done = '0; exp_rdata = '0; exp_err = 0; exp_busy = 0;
            return;
        end
        if ((!tv || e >= tg + tL + 2) && req != '0) begin
            tw = -1;
            for (int k = 0; k < N; k++) begin
                if (tw < 0 && req[(ptr + k) % N]) tw = (ptr + k) % N;
            end
            tv = 1; tg = e;
            if (force_d >= 0) td = force_d;
            else begin
                r = int'($urandom_range(0, 9));
                td = (r == 0) ? TO + 3 : (r == 1) ? TO : int'($urandom_range(1, 4));
            end
            tL = (td <= TO) ? td : TO;
            t_err = (td > TO);
            t_rdata = '0;
            t_wr = req_wr_rd_s[tw];
            exp_addr = ra[tw]; exp_wdata = rwd[tw]; exp_wr = req_wr_rd_s[tw];
            ptr = (tw + 1) % N;
        end
        if (tv && e - tg == td && td <= TO) t_rdata = t_wr ? 8'h00 : mem_rd_data;
        rel = e - tg;
        exp_sel  = tv && rel < tL;
        exp_busy = tv && rel <= tL;
        exp_done = '0;
        if (tv && rel == tL) exp_done[tw] = 1'b1;
        exp_rdata = (tv && rel == tL) ? t_rdata : 8'h00;
        exp_err   = tv && rel == tL && t_err;
    endtask

    task automatic compare_cycle();
        if (chk_en) begin
            chk("mem_sel_en", 32'(mem_sel_en), 32'(exp_sel));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wr_data", 32'(mem_wr_data), 32'(exp_wdata));
            chk("mem_wr_rd_s", 32'(mem_wr_rd_s), 32'(exp_wr));
            chk("done", 32'(done), 32'(exp_done));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("busy", 32'(busy), 32'(exp_busy));
        end
    endtask

    task automatic monitor();
        if (mem_sel_en === 1'b1) begin
            sel_cnt++;
            if (!prev_sel && seen_burst && low_run < min_gap) min_gap = low_run;
            seen_burst = 1;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_sel = (mem_sel_en === 1'b1);
        for (int i = 0; i < N; i++) if (done[i] === 1'b1) done_q.push_back(i);
        if (done !== '0) begin
            last_rdata = rsp_rdata;
            last_err = rsp_err;
        end
    endtask

    task automatic clear_logs();
        sel_cnt = 0; low_run = 0; min_gap = 999; prev_sel = 0; seen_burst = 0;
        done_q.delete();
        last_rdata = 8'hEE; last_err = 1'bx;
    endtask

    task automatic drive_inputs();
        int ne;
        int rel;
        for (int i = 0; i < N; i++) begin
            if (rand_mode) begin
                if (exp_done[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1; ra[i] = 8'($urandom); rwd[i] = 8'($urandom);
                    req_wr_rd_s[i] = 1'($urandom_range(0, 1));
                end else if (req[i] && exp_sel && tw == i && $urandom_range(0, 31) == 0)
                    req[i] = 1'b0;
            end else if (!hold_req && exp_done[i]) begin
                req[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
        end
        ne = e + 1;
        rel = ne - tg;
        if (tv && rel >= 1 && rel <= tL) mem_ack = (rel == td) && (td <= TO);
        else mem_ack = spur_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        mem_rd_data = (rd_fix >= 0) ? 8'(rd_fix) : 8'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        model_step();
        chk_en = 1;
        @(negedge clk);
        compare_cycle();
        monitor();
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] d, input logic w);
        ra[i] = a; rwd[i] = d; req_wr_rd_s[i] = w; req[i] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin ra[i] = '0; rwd[i] = '0; end
        @(negedge clk);
        run(2);
        chk("reset_sel", 32'(mem_sel_en), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Single write, ack on the third bus cycle.
        clear_logs(); force_d = 3;
        set_req(1, 8'h10, 8'hA5, 1'b1);
        run(10);
        chk("wr_sel_cycles", 32'(sel_cnt), 32'd3);
        chk("wr_done_count", 32'(done_q.size()), 32'd1);
        if (done_q.size() >= 1) chk("wr_done_idx", 32'(done_q[0]), 32'd1);
        chk("wr_err", 32'(last_err), 32'h0);
        chk("wr_rdata", 32'(last_rdata), 32'h0);

        // Read acked on the first bus cycle.
        clear_logs(); force_d = 1; rd_fix = 8'h3C;
        set_req(2, 8'h04, 8'h00, 1'b0);
        run(8);
        chk("rd_sel_cycles", 32'(sel_cnt), 32'd1);
        chk("rd_done_count", 32'(done_q.size()), 32'd1);
        if (done_q.size() >= 1) chk("rd_done_idx", 32'(done_q[0]), 32'd2);
        chk("rd_rdata", 32'(last_rdata), 32'h3C);
        chk("rd_err", 32'(last_err), 32'h0);
        rd_fix = -1;

        // Round-robin with all requests held from reset.
        rst_n = 1'b0; run(1); rst_n = 1'b1;
        clear_logs(); force_d = 2; hold_req = 1;
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h20 + i), 8'(8'h40 + i), 1'b1);
        run(21);
        req = '0; hold_req = 0;
        run(6);
        chk("rr_done_count_ge5", 32'(done_q.size() >= 5), 32'h1);
        if (done_q.size() >= 5) begin
            chk("rr_grant0", 32'(done_q[0]), 32'd0);
            chk("rr_grant1", 32'(done_q[1]), 32'd1);
            chk("rr_grant2", 32'(done_q[2]), 32'd2);
            chk("rr_grant3", 32'(done_q[3]), 32'd3);
            chk("rr_grant4", 32'(done_q[4]), 32'd0);
        end
        chk("rr_min_gap", 32'(min_gap), 32'd2);

        // Timeout with no ack at all.
        clear_logs(); force_d = 99;
        set_req(0, 8'h55, 8'h66, 1'b0);
        run(22);
        chk("to_sel_cycles", 32'(sel_cnt), 32'd16);
        chk("to_done_count", 32'(done_q.size()), 32'd1);
        chk("to_err", 32'(last_err), 32'h1);
        chk("to_rdata", 32'(last_rdata), 32'h0);

        // Ack on the same edge the timeout would expire.
        clear_logs(); force_d = 16; rd_fix = 8'h5A;
        set_req(2, 8'h77, 8'h00, 1'b0);
        run(22);
        chk("ackto_sel_cycles", 32'(sel_cnt), 32'd16);
        chk("ackto_err", 32'(last_err), 32'h0);
        chk("ackto_rdata", 32'(last_rdata), 32'h5A);
        rd_fix = -1;

        // Reset in the middle of a transaction; pointer must return to 0.
        force_d = 99;
        set_req(3, 8'h99, 8'h11, 1'b1);
        run(5);
        clear_logs();
        rst_n = 1'b0; run(1);
        chk("mid_rst_sel", 32'(mem_sel_en), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        rst_n = 1'b1; force_d = 1;
        req = '0;
        set_req(1, 8'hAB, 8'hCD, 1'b1);
        set_req(3, 8'hEF, 8'h01, 1'b1);
        run(8);
        chk("post_rst_done_count", 32'(done_q.size()), 32'd2);
        if (done_q.size() >= 2) begin
            chk("post_rst_first", 32'(done_q[0]), 32'd1);
            chk("post_rst_second", 32'(done_q[1]), 32'd3);
        end

        // Randomized traffic with spurious acks and occasional resets.
        force_d = -1; spur_en = 1; rand_mode = 1;
        run(4000);
        rand_mode = 0; spur_en = 0; req = '0; rst_n = 1'b1;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
